// File: rtl/sram_ctrl_if.sv
// LSU-side request/ack bundle for sram_ctrl.
// master (LSU): drives i_req, i_wren, i_addr, i_wdata, i_bmask.
// slave (sram_ctrl): drives o_rdata, o_ack, o_busy.
interface sram_ctrl_if;
  logic        i_req;
  logic        i_wren;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_req, i_wren, i_addr, i_wdata, i_bmask,
    input  o_rdata, o_ack, o_busy
  );

  modport slave (
    input  i_req, i_wren, i_addr, i_wdata, i_bmask,
    output o_rdata, o_ack, o_busy
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: serves 32-bit LSU loads/stores from a 16-bit asynchronous SRAM,
// as two halfword accesses (low half first), each held WAIT_CYCLES clocks.
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   lsu (slave)            request/ack bundle: req, wren, addr, wdata, bmask -> rdata, ack, busy
//   o_sram_addr            halfword address {word address, half}
//   io_sram_dq             bidirectional SRAM data bus
//   o_sram_*_n             active-low chip/write/output/byte-lane strobes
// All outputs are registered.
//
// state | meaning
// IDLE  | waiting for a request, strobes inactive
// RD_LO | reading low halfword  (addr bit 0 = 0)
// RD_HI | reading high halfword (addr bit 0 = 1)
// WR_LO | writing low halfword, lanes from bmask[1:0]
// WR_HI | writing high halfword, lanes from bmask[3:2]
// ACK   | one-cycle completion pulse, strobes inactive
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              i_clk,
  input  logic              i_reset,
  sram_ctrl_if.slave        lsu,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-2:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        bmask_q;
  logic [15:0]       rd_lo_q;
  logic [31:0]       rdata_q;
  logic              ack_q;
  logic              busy_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       dq_out_q;
  logic              dq_oe_q;
  logic              ce_n_q, we_n_q, oe_n_q, lb_n_q, ub_n_q;

  // Byte offset and address bits beyond the SRAM are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{lsu.i_addr[31:ADDR_W+1], lsu.i_addr[1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rd_lo_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu.i_req) begin
            waddr_q <= lsu.i_addr[ADDR_W:2];
            wdata_q <= lsu.i_wdata;
            bmask_q <= lsu.i_bmask;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            if (!lsu.i_wren) begin
              state_q     <= RD_LO;
              sram_addr_q <= {lsu.i_addr[ADDR_W:2], 1'b0};
              ce_n_q      <= 1'b0;
              oe_n_q      <= 1'b0;
              lb_n_q      <= 1'b0;
              ub_n_q      <= 1'b0;
            end else if (|lsu.i_bmask[1:0]) begin
              state_q     <= WR_LO;
              sram_addr_q <= {lsu.i_addr[ADDR_W:2], 1'b0};
              dq_out_q    <= lsu.i_wdata[15:0];
              dq_oe_q     <= 1'b1;
              ce_n_q      <= 1'b0;
              we_n_q      <= 1'b0;
              lb_n_q      <= ~lsu.i_bmask[0];
              ub_n_q      <= ~lsu.i_bmask[1];
            end else if (|lsu.i_bmask[3:2]) begin
              state_q     <= WR_HI;
              sram_addr_q <= {lsu.i_addr[ADDR_W:2], 1'b1};
              dq_out_q    <= lsu.i_wdata[31:16];
              dq_oe_q     <= 1'b1;
              ce_n_q      <= 1'b0;
              we_n_q      <= 1'b0;
              lb_n_q      <= ~lsu.i_bmask[2];
              ub_n_q      <= ~lsu.i_bmask[3];
            end else begin
              // Empty byte mask: nothing to write, complete at once.
              state_q <= ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        RD_LO: begin
          if (cnt_q == '0) begin
            rd_lo_q     <= io_sram_dq;
            state_q     <= RD_HI;
            sram_addr_q <= {waddr_q, 1'b1};
            cnt_q       <= CNT_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RD_HI: begin
          if (cnt_q == '0) begin
            rdata_q <= {io_sram_dq, rd_lo_q};
            state_q <= ACK;
            ack_q   <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WR_LO: begin
          if (cnt_q == '0) begin
            if (|bmask_q[3:2]) begin
              state_q     <= WR_HI;
              sram_addr_q <= {waddr_q, 1'b1};
              dq_out_q    <= wdata_q[31:16];
              lb_n_q      <= ~bmask_q[2];
              ub_n_q      <= ~bmask_q[3];
              cnt_q       <= CNT_LOAD;
            end else begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              dq_oe_q <= 1'b0;
              ce_n_q  <= 1'b1;
              we_n_q  <= 1'b1;
              lb_n_q  <= 1'b1;
              ub_n_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WR_HI: begin
          if (cnt_q == '0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lsu.o_rdata  = rdata_q;
  assign lsu.o_ack    = ack_q;
  assign lsu.o_busy   = busy_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_lb_n  = lb_n_q;
  assign o_sram_ub_n  = ub_n_q;
  // dq_oe_q is only set in write states, where oe_n is high.
  assign io_sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule
